riscv_if_stage: RTL and testbench
=================================

// Module: riscv_if_stage
// PURPOSE
//  Instruction-fetch stage: owns the PC register, drives the instruction-memory address and holds the IF/ID pipeline register.
//  Consumes flush/BranchTaken from riscv_control_hazard (branch resolved in MEM, static not-taken prediction).
//  Consumes the load-use stall from the data-hazard unit.
//  On flush, redirects the PC to the resolved target and turns IF/ID into a bubble.
// PARAMETERS
//  XLEN       32            datapath / PC width
//  RESET_PC   32'h0000_0000 PC value loaded by reset
//  NOP_INSTR  32'h0000_0013 instruction word inserted as a bubble (addi x0,x0,0)
// PORTS
//  clk              in   1     system clock, rising edge
//  rst_n            in   1     asynchronous, active-low reset
//  stall_i          in   1     load-use stall: hold PC and IF/ID
//  flush_i          in   1     mispredict flush from riscv_control_hazard
//  branch_target_i  in   XLEN  resolved branch/jump target (from EX/MEM)
//  imem_addr_o      out  XLEN  instruction-memory address (= pc_q, combinational read)
//  imem_rdata_i     in   32    instruction word at imem_addr_o, same cycle
//  if_id_pc_o       out  XLEN  PC of the instruction in IF/ID
//  if_id_pc4_o      out  XLEN  if_id_pc_o + 4 (link value for JAL/JALR)
//  if_id_instr_o    out  32    instruction in IF/ID (NOP_INSTR when bubble)
//  if_id_valid_o    out  1     1 = real instruction, 0 = bubble
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - pc_q=RESET_PC; if_id_pc_o=RESET_PC; if_id_pc4_o=RESET_PC+4.
//   - if_id_instr_o=NOP_INSTR; if_id_valid_o=0; state=BOOT.
//  States (2-state FSM, encoding in riscv_define.v):
//   - BOOT: first edge after reset release. pc_q stays RESET_PC; IF/ID loads a bubble; go to RUN.
//     Guarantees one clean bubble before the first real fetch.
//   - RUN: normal operation; stays in RUN until reset.
//  Per rising edge in RUN, in priority order:
//   1. flush_i=1:
//      - pc_q <= {branch_target_i[XLEN-1:2],2'b00} (low bits forced to 0; no misalign trap).
//      - IF/ID <= bubble: instr=NOP_INSTR, valid=0, pc fields <= current pc_q / pc_q+4.
//      - Flush beats stall when both are asserted.
//   2. stall_i=1: pc_q and all IF/ID outputs hold their values.
//   3. else:
//      - pc_q <= pc_q+4.
//      - IF/ID <= {pc_q, pc_q+4, imem_rdata_i, valid=1}.
//  Latency: instruction at pc_q appears on if_id_* one edge later.
//  First valid instruction: the 2nd edge after rst_n rises (BOOT edge, then first RUN edge).
//  Redirect penalty: target appears on imem_addr_o the cycle after the flush edge.
//  Arithmetic: pc+4 is modulo 2^XLEN; 32'hFFFF_FFFC+4 -> 0, no flag.
//  flush_i/stall_i during BOOT are ignored; BOOT always completes to RUN.
//  Reset mid-operation: all state returns to reset values immediately, regardless of clk.
//  imem_addr_o is pure wiring from pc_q; no other combinational path from inputs to outputs.
// STRUCTURE
//  Shared (riscv_define.v):
//   - `XLEN width macros.
//   - `NOP_INSTR.
//   - `IF_BOOT / `IF_RUN state codes.
//  Sub-module riscv_pc_reg:
//   - PC register with the flush>stall>increment next-PC mux and async reset.
//  Top-level riscv_if_stage:
//   - Instantiates riscv_pc_reg.
//   - Holds the FSM and the IF/ID register.
// TESTING
//  T1 reset, no stalls, imem returns A,B,C at 0,4,8:
//     release rst_n -> edge1 valid=0; edge2 {pc=0,instr=A,valid=1}; edge3 {4,B,1}.
//  T2 stall_i=1 for 2 cycles at pc_q=8:
//     imem_addr_o stays 8 and IF/ID holds {4,B,1} both cycles; resumes to {8,C,1}.
//  T3 flush_i=1, target=32'h100 at pc_q=0x10:
//     next edge pc_q=0x100 and IF/ID {pc=0x10,NOP,valid=0}; following edge instr@0x100 valid=1.
//  T4 flush_i=1 and stall_i=1 together, target=0x200:
//     pc_q=0x200 and IF/ID bubble (flush wins).
//  T5 target=32'h103 -> pc_q=0x100.
//     pc_q=32'hFFFF_FFFC, no stall -> pc_q=0 and if_id_pc4_o=0.
//  T6 assert rst_n=0 between clock edges mid-run:
//     outputs return to reset values immediately; BOOT bubble observed after release.

Source files
------------

// File: rtl/riscv_if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths,
// the bubble instruction word and the fetch FSM state codes.
package riscv_if_stage_pkg;

    // Default datapath / PC width
    localparam int DEFAULT_XLEN = 32;

    // PC value loaded by reset
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Bubble instruction: addi x0,x0,0
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    // Every instruction is one 32-bit word, so the sequential PC step is 4
    localparam int INSTR_BYTES = 4;

    // Fetch FSM: BOOT spends exactly one edge injecting a clean bubble,
    // then RUN handles flush/stall/increment until the next reset
    typedef enum logic {
        IF_BOOT = 1'b0,
        IF_RUN  = 1'b1
    } if_state_e;

endpackage : riscv_if_stage_pkg

// File: rtl/riscv_pc_reg.sv
// Program counter register for the fetch stage. The next-PC priority is
// flush (redirect to the resolved target), then stall (hold), then the
// sequential pc+4. While the fetch FSM is still booting the PC holds.
module riscv_pc_reg
    import riscv_if_stage_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    logic [XLEN-1:0] pc_next;

    // The two low target bits are dropped on purpose: a misaligned target is
    // silently word-aligned instead of raising a trap.
    logic unused_target_bits;
    assign unused_target_bits = ^target[1:0];

    // Sequential successor; the add wraps modulo 2^XLEN with no carry out.
    assign pc_plus4 = pc + XLEN'(INSTR_BYTES);

    // Next-PC select: redirect beats stall, stall beats increment; hold while booting
    always_comb begin
        pc_next = pc;
        if (run) begin
            if (flush) begin
                pc_next = {target[XLEN-1:2], 2'b00};
            end else if (!stall) begin
                pc_next = pc_plus4;
            end
        end
    end

    // PC state register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule : riscv_pc_reg

// File: rtl/riscv_if_stage.sv
// Instruction-fetch stage: owns the PC (via riscv_pc_reg), presents it as
// the instruction-memory address and holds the IF/ID pipeline register.
// Branches resolve in MEM with static not-taken prediction, so a flush
// redirects the PC and turns the IF/ID slot into a bubble.
module riscv_if_stage
    import riscv_if_stage_pkg::*;
#(
    parameter int              XLEN      = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEFAULT_RESET_PC),
    parameter logic [31:0]     NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [31:0]     imem_rdata_i,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_pc4_o,
    output logic [31:0]     if_id_instr_o,
    output logic            if_id_valid_o
);

    localparam logic [XLEN-1:0] RESET_PC4 = RESET_PC + XLEN'(INSTR_BYTES);

    if_state_e       state_q;
    if_state_e       state_d;
    logic            run;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4;

    logic [XLEN-1:0] if_id_pc_q;
    logic [XLEN-1:0] if_id_pc_d;
    logic [XLEN-1:0] if_id_pc4_q;
    logic [XLEN-1:0] if_id_pc4_d;
    logic [31:0]     if_id_instr_q;
    logic [31:0]     if_id_instr_d;
    logic            if_id_valid_q;
    logic            if_id_valid_d;

    assign run = (state_q == IF_RUN);

    riscv_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .stall    (stall_i),
        .flush    (flush_i),
        .target   (branch_target_i),
        .pc       (pc_q),
        .pc_plus4 (pc_plus4)
    );

    // Memory is read combinationally at the current PC; no other input reaches an output
    assign imem_addr_o   = pc_q;
    assign if_id_pc_o    = if_id_pc_q;
    assign if_id_pc4_o   = if_id_pc4_q;
    assign if_id_instr_o = if_id_instr_q;
    assign if_id_valid_o = if_id_valid_q;

    // Fetch FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IF_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and IF/ID next value: BOOT bubbles once, RUN applies flush > stall > fetch
    always_comb begin
        state_d       = state_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;

        unique case (state_q)
            IF_BOOT: begin
                state_d       = IF_RUN;
                if_id_pc_d    = pc_q;
                if_id_pc4_d   = pc_plus4;
                if_id_instr_d = NOP_INSTR;
                if_id_valid_d = 1'b0;
            end
            IF_RUN: begin
                if (flush_i) begin
                    if_id_pc_d    = pc_q;
                    if_id_pc4_d   = pc_plus4;
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                end else if (!stall_i) begin
                    if_id_pc_d    = pc_q;
                    if_id_pc4_d   = pc_plus4;
                    if_id_instr_d = imem_rdata_i;
                    if_id_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IF_BOOT;
            end
        endcase
    end

    // IF/ID pipeline register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_pc_q    <= RESET_PC;
            if_id_pc4_q   <= RESET_PC4;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            if_id_pc_q    <= if_id_pc_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

endmodule : riscv_if_stage

// File: tb/tb_riscv_if_stage.sv
// Self-checking bench for riscv_if_stage: directed vectors with
// hand-computed expectations plus a per-cycle comparison against a
// behavioural model of the fetch stage.
module tb_riscv_if_stage;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] INS_A = 32'h0050_0093;
    localparam logic [31:0] INS_B = 32'h00A0_0113;
    localparam logic [31:0] INS_C = 32'h0020_81B3;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] branch_target_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;

    int checks_total;
    int checks_passed;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_if_pc;
    logic [31:0] m_if_pc4;
    logic [31:0] m_if_instr;
    logic        m_if_valid;
    bit          m_booting;

    riscv_if_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_target_i (branch_target_i),
        .imem_addr_o     (imem_addr_o),
        .imem_rdata_i    (imem_rdata_i),
        .if_id_pc_o      (if_id_pc_o),
        .if_id_pc4_o     (if_id_pc4_o),
        .if_id_instr_o   (if_id_instr_o),
        .if_id_valid_o   (if_id_valid_o)
    );

    // Instruction memory contents: three known words, then an address-tagged pattern
    function automatic logic [31:0] imem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: imem_word = INS_A;
            32'h0000_0004: imem_word = INS_B;
            32'h0000_0008: imem_word = INS_C;
            default:       imem_word = {16'hC0DE, addr[15:0]};
        endcase
    endfunction

    always_comb imem_rdata_i = imem_word(imem_addr_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports a FAIL line on disagreement
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive the inputs for the next edge, then return 1 time unit after that edge
    task automatic applyStimulus(input logic stall, input logic flush, input logic [31:0] target);
        stall_i         = stall;
        flush_i         = flush;
        branch_target_i = target;
        @(posedge clk);
        #1;
    endtask

    // Model of the fetch stage: a one-edge bubble after reset, then flush > stall > fetch
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc       = 32'h0;
            m_if_pc    = 32'h0;
            m_if_pc4   = 32'h4;
            m_if_instr = NOP;
            m_if_valid = 1'b0;
            m_booting  = 1'b1;
        end else if (m_booting) begin
            m_booting  = 1'b0;
            m_if_pc    = m_pc;
            m_if_pc4   = m_pc + 32'd4;
            m_if_instr = NOP;
            m_if_valid = 1'b0;
        end else if (flush_i) begin
            m_if_pc    = m_pc;
            m_if_pc4   = m_pc + 32'd4;
            m_if_instr = NOP;
            m_if_valid = 1'b0;
            m_pc       = branch_target_i & 32'hFFFF_FFFC;
        end else if (!stall_i) begin
            m_if_pc    = m_pc;
            m_if_pc4   = m_pc + 32'd4;
            m_if_instr = imem_word(m_pc);
            m_if_valid = 1'b1;
            m_pc       = m_pc + 32'd4;
        end
    end

    // Every falling edge: all outputs against the model
    always @(negedge clk) begin
        checkOutput("model imem_addr", imem_addr_o, m_pc);
        checkOutput("model if_id_pc", if_id_pc_o, m_if_pc);
        checkOutput("model if_id_pc4", if_id_pc4_o, m_if_pc4);
        checkOutput("model if_id_instr", if_id_instr_o, m_if_instr);
        checkOutput("model if_id_valid", {31'b0, if_id_valid_o}, {31'b0, m_if_valid});
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks_total    = 0;
        checks_passed   = 0;
        rst_n           = 1'b0;
        stall_i         = 1'b0;
        flush_i         = 1'b0;
        branch_target_i = 32'h0;

        // Reset state
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("reset imem_addr", imem_addr_o, 32'h0);
        checkOutput("reset if_id_pc4", if_id_pc4_o, 32'h4);
        checkOutput("reset if_id_instr", if_id_instr_o, NOP);
        checkOutput("reset if_id_valid", {31'b0, if_id_valid_o}, 32'h0);

        // T1: release between edges, BOOT bubble then A, B
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("T1 boot valid", {31'b0, if_id_valid_o}, 32'h0);
        checkOutput("T1 boot pc held", imem_addr_o, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("T1 e2 pc", if_id_pc_o, 32'h0);
        checkOutput("T1 e2 instr", if_id_instr_o, INS_A);
        checkOutput("T1 e2 valid", {31'b0, if_id_valid_o}, 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("T1 e3 pc", if_id_pc_o, 32'h4);
        checkOutput("T1 e3 instr", if_id_instr_o, INS_B);
        checkOutput("T1 e3 addr", imem_addr_o, 32'h8);

        // T2: two stall cycles at pc 8, then resume
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            checkOutput("T2 stall addr", imem_addr_o, 32'h8);
            checkOutput("T2 stall pc", if_id_pc_o, 32'h4);
            checkOutput("T2 stall instr", if_id_instr_o, INS_B);
        end
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("T2 resume pc", if_id_pc_o, 32'h8);
        checkOutput("T2 resume instr", if_id_instr_o, INS_C);
        checkOutput("T2 resume valid", {31'b0, if_id_valid_o}, 32'h1);

        // T3: flush to 0x100 while pc is 0x10
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("T3 pre addr", imem_addr_o, 32'h10);
        applyStimulus(1'b0, 1'b1, 32'h100);
        checkOutput("T3 redirect addr", imem_addr_o, 32'h100);
        checkOutput("T3 bubble pc", if_id_pc_o, 32'h10);
        checkOutput("T3 bubble pc4", if_id_pc4_o, 32'h14);
        checkOutput("T3 bubble instr", if_id_instr_o, NOP);
        checkOutput("T3 bubble valid", {31'b0, if_id_valid_o}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("T3 target pc", if_id_pc_o, 32'h100);
        checkOutput("T3 target instr", if_id_instr_o, 32'hC0DE_0100);
        checkOutput("T3 target valid", {31'b0, if_id_valid_o}, 32'h1);

        // T4: flush and stall together, flush wins
        applyStimulus(1'b1, 1'b1, 32'h200);
        checkOutput("T4 addr", imem_addr_o, 32'h200);
        checkOutput("T4 pc", if_id_pc_o, 32'h104);
        checkOutput("T4 instr", if_id_instr_o, NOP);
        checkOutput("T4 valid", {31'b0, if_id_valid_o}, 32'h0);

        // T5: misaligned target is word-aligned; PC wraps past the top of memory
        applyStimulus(1'b0, 1'b1, 32'h103);
        checkOutput("T5 align addr", imem_addr_o, 32'h100);
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
        checkOutput("T5 top addr", imem_addr_o, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("T5 wrap addr", imem_addr_o, 32'h0);
        checkOutput("T5 wrap pc", if_id_pc_o, 32'hFFFF_FFFC);
        checkOutput("T5 wrap pc4", if_id_pc4_o, 32'h0);
        checkOutput("T5 wrap instr", if_id_instr_o, 32'hC0DE_FFFC);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);

        // T6: asynchronous reset between edges, then BOOT ignores flush/stall
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("T6 async addr", imem_addr_o, 32'h0);
        checkOutput("T6 async pc", if_id_pc_o, 32'h0);
        checkOutput("T6 async pc4", if_id_pc4_o, 32'h4);
        checkOutput("T6 async instr", if_id_instr_o, NOP);
        checkOutput("T6 async valid", {31'b0, if_id_valid_o}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h300);
        checkOutput("T6 boot addr", imem_addr_o, 32'h0);
        checkOutput("T6 boot valid", {31'b0, if_id_valid_o}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("T6 first pc", if_id_pc_o, 32'h0);
        checkOutput("T6 first instr", if_id_instr_o, INS_A);
        checkOutput("T6 first valid", {31'b0, if_id_valid_o}, 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("T6 second instr", if_id_instr_o, INS_B);

        @(negedge clk);
        #1;
        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule : tb_riscv_if_stage
